// File: rtl/rle_pkg.sv
// Shared run-length encoding definitions, used by the encoder RTL and by the
// host-side decoder model so that both agree on word layout.
package rle_pkg;

  // Default total word width of the capture path.
  localparam int RLE_DEFAULT_WIDTH = 32;

  // Flag values carried in the MSB of every output word.
  localparam logic RLE_FLAG_VALUE = 1'b0;  // payload is a sample
  localparam logic RLE_FLAG_COUNT = 1'b1;  // payload is extra repeats of prior value

  // Index of the flag bit for a given word width.
  function automatic int rle_flag_bit(input int width);
    return width - 1;
  endfunction

  // Largest count a single count word can carry (all payload bits set).
  function automatic longint unsigned rle_cmax(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/rle_encoder.sv
// Run-length encoder for the analyzer sample path. Repeated samples collapse
// into count words; a one-entry pending register absorbs the single word of
// backlog created when a count word and a new value want the same slot.
// With rle_en=0 the block is a registered one-cycle passthrough.
module rle_encoder
  import rle_pkg::*;
#(
  parameter int WIDTH = RLE_DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             validIn,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             rle_en,
  input  logic             flush,
  output logic             validOut,
  output logic [WIDTH-1:0] dataOut,
  output logic             idle
);

  localparam int            PW   = WIDTH - 1;
  localparam int            FLAG = rle_flag_bit(WIDTH);
  localparam logic [PW-1:0] CMAX = PW'(rle_cmax(WIDTH));

  // Registered state
  logic [PW-1:0]    r_last;
  logic             r_have_last;
  logic [PW-1:0]    r_count;
  logic             r_pend_valid;
  logic [PW-1:0]    r_pend;
  logic             r_valid_out;
  logic [WIDTH-1:0] r_data_out;

  // Next-state values
  logic [PW-1:0]    w_last;
  logic             w_have_last;
  logic [PW-1:0]    w_count;
  logic             w_pend_valid;
  logic [PW-1:0]    w_pend;
  logic             w_valid_out;
  logic [WIDTH-1:0] w_data_out;

  // Decode helpers
  logic [PW-1:0]    w_sample;
  logic [PW-1:0]    w_count_inc;
  logic             w_repeat;

  // Build an output word from a flag and a payload.
  function automatic logic [WIDTH-1:0] mk_word(input logic flag, input logic [PW-1:0] payload);
    logic [WIDTH-1:0] w;
    w           = '0;
    w[FLAG]     = flag;
    w[PW-1:0]   = payload;
    return w;
  endfunction

  assign w_sample    = dataIn[PW-1:0];
  assign w_count_inc = r_count + PW'(1);
  assign w_repeat    = r_have_last && (w_sample == r_last);

  // Next-state and emission selection; at most one word leaves per cycle.
  always_comb begin
    w_last       = r_last;
    w_have_last  = r_have_last;
    w_count      = r_count;
    w_pend_valid = r_pend_valid;
    w_pend       = r_pend;
    w_valid_out  = 1'b0;
    w_data_out   = r_data_out;

    if (!rle_en) begin
      // Passthrough: forward raw word, discard any encoder leftovers.
      w_valid_out  = validIn;
      w_data_out   = dataIn;
      w_count      = '0;
      w_pend_valid = 1'b0;
      w_have_last  = 1'b0;
    end else if (validIn) begin
      if (w_repeat) begin
        if (w_count_inc == CMAX) begin
          // Saturated: ship a full count word and keep counting from zero.
          // pend is necessarily empty here since count>0 already drained it.
          w_valid_out = 1'b1;
          w_data_out  = mk_word(RLE_FLAG_COUNT, CMAX);
          w_count     = '0;
        end else begin
          // Repeat slot produces no word of its own; use it to drain pend.
          w_count = w_count_inc;
          if (r_pend_valid) begin
            w_valid_out  = 1'b1;
            w_data_out   = mk_word(RLE_FLAG_VALUE, r_pend);
            w_pend_valid = 1'b0;
          end
        end
      end else begin
        if (r_count != '0) begin
          // Close the run; the new value has to wait one slot.
          w_valid_out  = 1'b1;
          w_data_out   = mk_word(RLE_FLAG_COUNT, r_count);
          w_pend       = w_sample;
          w_pend_valid = 1'b1;
        end else if (r_pend_valid) begin
          // Older value goes first; the new one takes its place in pend.
          w_valid_out = 1'b1;
          w_data_out  = mk_word(RLE_FLAG_VALUE, r_pend);
          w_pend      = w_sample;
        end else begin
          w_valid_out = 1'b1;
          w_data_out  = mk_word(RLE_FLAG_VALUE, w_sample);
        end
        w_last      = w_sample;
        w_have_last = 1'b1;
        w_count     = '0;
      end
    end else begin
      if (r_pend_valid) begin
        w_valid_out  = 1'b1;
        w_data_out   = mk_word(RLE_FLAG_VALUE, r_pend);
        w_pend_valid = 1'b0;
      end else if (flush && (r_count != '0)) begin
        w_valid_out = 1'b1;
        w_data_out  = mk_word(RLE_FLAG_COUNT, r_count);
        w_count     = '0;
      end else if (flush) begin
        // Fully drained: forget the last value so the next capture restarts.
        w_have_last = 1'b0;
      end
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last       <= '0;
      r_have_last  <= 1'b0;
      r_count      <= '0;
      r_pend_valid <= 1'b0;
      r_pend       <= '0;
      r_valid_out  <= 1'b0;
      r_data_out   <= '0;
    end else begin
      r_last       <= w_last;
      r_have_last  <= w_have_last;
      r_count      <= w_count;
      r_pend_valid <= w_pend_valid;
      r_pend       <= w_pend;
      r_valid_out  <= w_valid_out;
      r_data_out   <= w_data_out;
    end
  end

  assign validOut = r_valid_out;
  assign dataOut  = r_data_out;
  assign idle     = !r_pend_valid && (r_count == '0);

endmodule

// File: tb/tb_rle_encoder.sv
// Bench for rle_encoder at WIDTH=8: a table of per-cycle stimulus with the
// word expected one cycle later, fed through a scoreboard queue, plus
// hand-written saturation and reset sequences.
module tb_rle_encoder;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         validIn;
  logic [W-1:0] dataIn;
  logic         rle_en;
  logic         flush;
  logic         validOut;
  logic [W-1:0] dataOut;
  logic         idle;

  typedef struct {
    int           id;
    logic         en;
    logic         vin;
    logic         fl;
    logic [W-1:0] din;
    logic         ev;     // word expected after this cycle's edge
    logic [W-1:0] ed;
    logic         eidle;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  vec_t mon_e;
  int   nvec   = 0;
  int   errors = 0;

  rle_encoder #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .validIn (validIn),
    .dataIn  (dataIn),
    .rle_en  (rle_en),
    .flush   (flush),
    .validOut(validOut),
    .dataOut (dataOut),
    .idle    (idle)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input int id, input logic en, input logic vin, input logic fl,
                              input logic [W-1:0] din, input logic ev, input logic [W-1:0] ed,
                              input logic eidle);
    vec_t v;
    v.id = id; v.en = en; v.vin = vin; v.fl = fl; v.din = din;
    v.ev = ev; v.ed = ed; v.eidle = eidle;
    return v;
  endfunction

  task automatic add(input logic en, input logic vin, input logic fl, input logic [W-1:0] din,
                     input logic ev, input logic [W-1:0] ed, input logic eidle);
    tbl.push_back(mk(tbl.size(), en, vin, fl, din, ev, ed, eidle));
  endtask

  // Drive one cycle of stimulus and queue its expected result.
  task automatic step(input vec_t v);
    @(negedge clock);
    rle_en  = v.en;
    validIn = v.vin;
    flush   = v.fl;
    dataIn  = v.din;
    exp_q.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    nvec++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h, required %02h", nm, act, req);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) @(posedge clock);
    #2;
    nvec++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Output monitor: one expectation per driven cycle, sampled after the edge.
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      if (dut.r_pend_valid && (dut.r_count != '0)) begin
        errors++;
        $display("FAIL invariant: pend_valid=1 with count=%0d, required count=0", dut.r_count);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        nvec++;
        if (validOut !== mon_e.ev || (mon_e.ev && dataOut !== mon_e.ed) || idle !== mon_e.eidle) begin
          errors++;
          $display("FAIL vec%0d: validOut=%0b dataOut=%02h idle=%0b, required validOut=%0b dataOut=%02h idle=%0b",
                   mon_e.id, validOut, dataOut, idle, mon_e.ev, mon_e.ed, mon_e.eidle);
        end
      end else if (validOut) begin
        errors++;
        $display("FAIL unexpected word: validOut=1 dataOut=%02h, required validOut=0", dataOut);
      end
    end
  end

  initial begin
    reset = 1'b1; validIn = 1'b0; dataIn = '0; rle_en = 1'b1; flush = 1'b0;

    // Run then change: 05 x3, 09
    add(1,1,0,8'h05, 1,8'h05,1);
    add(1,1,0,8'h05, 0,8'h00,0);
    add(1,1,0,8'h05, 0,8'h00,0);
    add(1,1,0,8'h09, 1,8'h82,0);
    add(1,0,0,8'h00, 1,8'h09,1);
    add(1,0,1,8'h00, 0,8'h00,1);
    // Distinct samples
    add(1,1,0,8'h01, 1,8'h01,1);
    add(1,1,0,8'h02, 1,8'h02,1);
    add(1,1,0,8'h03, 1,8'h03,1);
    add(1,0,1,8'h00, 0,8'h00,1);
    // Backlog chain
    add(1,1,0,8'h05, 1,8'h05,1);
    add(1,1,0,8'h05, 0,8'h00,0);
    add(1,1,0,8'h09, 1,8'h81,0);
    add(1,1,0,8'h0A, 1,8'h09,0);
    add(1,1,0,8'h0B, 1,8'h0A,0);
    add(1,0,0,8'h00, 1,8'h0B,1);
    add(1,0,1,8'h00, 0,8'h00,1);
    // Count held across a gap without flush
    add(1,1,0,8'h03, 1,8'h03,1);
    add(1,1,0,8'h03, 0,8'h00,0);
    add(1,0,0,8'h00, 0,8'h00,0);
    add(1,1,0,8'h03, 0,8'h00,0);
    add(1,1,0,8'h04, 1,8'h82,0);
    add(1,0,0,8'h00, 1,8'h04,1);
    add(1,0,1,8'h00, 0,8'h00,1);
    // flush together with validIn, then drain, then fresh run of same value
    add(1,1,0,8'h07, 1,8'h07,1);
    add(1,1,0,8'h07, 0,8'h00,0);
    add(1,1,1,8'h07, 0,8'h00,0);
    add(1,0,1,8'h00, 1,8'h82,1);
    add(1,0,1,8'h00, 0,8'h00,1);
    add(1,1,0,8'h07, 1,8'h07,1);
    add(1,0,1,8'h00, 0,8'h00,1);
    // Passthrough: MSB intact, no compression, flush ignored
    add(0,1,0,8'hAB, 1,8'hAB,1);
    add(0,1,0,8'h85, 1,8'h85,1);
    add(0,1,0,8'h05, 1,8'h05,1);
    add(0,1,0,8'h05, 1,8'h05,1);
    add(0,0,1,8'h00, 0,8'h00,1);
    add(0,0,0,8'h00, 0,8'h00,1);

    #12;
    chk("reset validOut", {7'd0, validOut}, 8'h00);
    chk("reset dataOut", dataOut, 8'h00);
    chk("reset idle", {7'd0, idle}, 8'h01);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
    drain();

    // Saturation: 130 x 11 then flush
    step(mk(1000, 1,1,0,8'h11, 1,8'h11,1));
    for (int i = 2; i <= 130; i++) begin
      if (i == 128) step(mk(1000+i, 1,1,0,8'h11, 1,8'hFF,1));
      else          step(mk(1000+i, 1,1,0,8'h11, 0,8'h00,0));
    end
    step(mk(1200, 1,0,1,8'h00, 1,8'h82,1));
    step(mk(1201, 1,0,1,8'h00, 0,8'h00,1));
    drain();

    // Reset while a word is on the output
    step(mk(2000, 1,1,0,8'h0C, 1,8'h0C,1));
    @(posedge clock); #2;
    reset = 1'b1; validIn = 1'b0;
    #1;
    chk("reset async validOut", {7'd0, validOut}, 8'h00);
    chk("reset async dataOut", dataOut, 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // Reset mid-run drops the count
    step(mk(2100, 1,1,0,8'h05, 1,8'h05,1));
    step(mk(2101, 1,1,0,8'h05, 0,8'h00,0));
    step(mk(2102, 1,1,0,8'h05, 0,8'h00,0));
    @(posedge clock); #2;
    reset = 1'b1; validIn = 1'b0;
    #1;
    chk("midrun reset validOut", {7'd0, validOut}, 8'h00);
    chk("midrun reset idle", {7'd0, idle}, 8'h01);
    @(negedge clock);
    reset = 1'b0;
    step(mk(2200, 1,1,0,8'h07, 1,8'h07,1));
    step(mk(2201, 1,0,0,8'h00, 0,8'h00,1));
    step(mk(2202, 1,0,1,8'h00, 0,8'h00,1));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errors);
    $finish;
  end

endmodule

// File: doc/rle_encoder.md
Name: rle_encoder

Overview:
- Run-length encoder in the analyzer sample path, directly downstream of the sample delay FIFO.
- Consumes the delayed sample stream (validIn/dataIn) and writes a compressed word stream to the capture memory writer.
- Repeated samples collapse into a count word, giving long idle captures far more depth.
- With rle_en=0 it is a one-cycle registered passthrough.

Parameters:
WIDTH, 32, total word width. Must be >= 3. Bit WIDTH-1 is the RLE flag; bits WIDTH-2:0 carry the payload.
- Derived constant CMAX = 2^(WIDTH-1)-1 (all payload bits 1).

Ports:
clock  in  1  sole clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high; clears all state and outputs immediately
validIn  in  1  input sample strobe, may be asserted every cycle
dataIn  in  WIDTH  input sample; the MSB is ignored when rle_en=1
rle_en  in  1  1 = encode, 0 = passthrough; changed only while idle=1
flush  in  1  level request to drain held count/value at end of capture
validOut  out  1  output word strobe, registered
dataOut  out  WIDTH  output word, registered. MSB=0: value word (payload = sample). MSB=1: count word (payload = additional repeats of preceding value).
idle  out  1  1 when pend_valid=0 and count=0, combinational from registers

Behaviour:
- Reset values: validOut=0, dataOut=0, idle=1, count=0, pend_valid=0, have_last=0, last=0.
- Internal state:
  - last[WIDTH-2:0] and have_last.
  - count[WIDTH-2:0].
  - One-entry pending value register (pend_valid, pend).
- validOut is deasserted on any cycle where no rule below emits a word.
- Passthrough (rle_en=0):
  - validOut<=validIn and dataOut<=dataIn, latency 1, MSB preserved.
  - count, pend_valid and have_last are held at 0; any leftover state is discarded.
  - flush has no effect.
- Encode mode, cycle with validIn=1, s=dataIn[WIDTH-2:0]:
  - Repeat (have_last=1 and s==last):
    - n=count+1.
    - If n==CMAX: emit {1,CMAX} and set count<=0. Saturation chains; the decoder sums consecutive count words.
    - Otherwise: count<=n, and emit pend if pend_valid, then clear pend_valid.
  - Change, or first sample:
    - If count>0: emit {1,count}, pend<=s, pend_valid<=1.
    - Else if pend_valid: emit {0,pend}, pend<=s.
    - Else: emit {0,s}.
    - In all three cases: last<=s, have_last<=1, count<=0.
- Encode mode, cycle with validIn=0:
  - If pend_valid: emit {0,pend} and clear pend_valid.
  - Else if flush and count>0: emit {1,count} and set count<=0.
  - Else if flush: have_last<=0, so the next sample starts a fresh run.
  - Otherwise nothing is emitted; count and last are held.
- Invariant: pend_valid=1 and count>0 never hold together.
  - Every run with count>0 has had a repeat slot that drained pend.
  - The backlog is therefore at most one word, and there is no input backpressure.
  - The bench asserts this invariant.
- flush arriving together with validIn: the input is processed first; the drain occurs on the next validIn=0 cycles while flush is held.
- The capture controller holds flush until idle=1.
- Latency: a value word that is not deferred appears 1 cycle after its input. A deferred value appears 1 cycle after the next emission slot.
- Reset mid-run drops count and pend; no stale words appear after reset deasserts.

Decomposition:
- Shared package rle_pkg holds:
  - function rle_cmax(width);
  - localparams for the flag bit index (WIDTH-1) and the flag values VALUE=0, COUNT=1.
- The downstream decoder in the host-side model uses the same package.
- No sub-module; a single flat module.

Test Plan (WIDTH=8, CMAX=127):
- Run then change:
  - Stimulus: 05,05,05,09 on consecutive cycles, then idle.
  - Required: 05 @c1, 82 @c4, 09 @c5, no other words.
- Distinct samples: 01,02,03 back-to-back -> 01,02,03 @c1..c3; idle=1 throughout.
- Backlog chain:
  - Stimulus: 05,05,09,0A,0B back-to-back.
  - Required: 05 @c1, 81 @c3, 09 @c4, 0A @c5, 0B @c6; pend_valid and count never both set.
- Saturation plus flush:
  - Stimulus: 130 consecutive 11, then flush.
  - Required: 11, then FF after the 128th input, then 82 on flush, then idle=1.
- Passthrough: rle_en=0, input AB then 85 -> AB, 85 one cycle later each, MSB intact.
- Reset mid-run:
  - Stimulus: 05,05,05, then reset pulsed.
  - Required: validOut=0 immediately and idle=1.
  - After reset, input 07 -> 07 with no 82 emitted.
